// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser plus counter debounce on five
// independent channels; up/down buttons additionally emit a one-cycle press pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btnc_in,
    input  logic btnl_in,
    input  logic btnr_in,
    input  logic btnu_in,
    input  logic btnd_in,
    output logic btnc,
    output logic btnl,
    output logic btnr,
    output logic btnu_pulse,
    output logic btnd_pulse
);

    localparam int N_CH = 5;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: 0=centre, 1=left, 2=right, 3=up, 4=down.
    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  s1_q, s1_d;
    logic [N_CH-1:0]  s2_q, s2_d;
    logic [N_CH-1:0]  st_q, st_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [1:0]       pulse_q, pulse_d;
    logic [N_CH-1:0]  rise;

    assign raw = {btnd_in, btnu_in, btnr_in, btnl_in, btnc_in};

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        st_d = st_q;
        rise = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = s2_q[i];
                    rise[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Pulse lands on the same edge as the debounced 0->1 flip; releases are ignored.
        pulse_d = {rise[4], rise[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            st_q    <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            st_q    <= st_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btnc       = st_q[0];
    assign btnl       = st_q[1];
    assign btnr       = st_q[2];
    assign btnu_pulse = pulse_q[0];
    assign btnd_pulse = pulse_q[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity,
// each edge compared against a history-window reference model.
module tb_btn_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnc_in = 1'b0, btnl_in = 1'b0, btnr_in = 1'b0, btnu_in = 1'b0, btnd_in = 1'b0;
    logic btnc, btnl, btnr, btnu_pulse, btnd_pulse;

    int checks = 0;
    int passed = 0;
    int edge_n = 0;
    int u_cnt = 0, d_cnt = 0, first_u = -1, first_d = -1;
    int l_seen = 0;

    btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .btnc_in(btnc_in), .btnl_in(btnl_in), .btnr_in(btnr_in),
        .btnu_in(btnu_in), .btnd_in(btnd_in),
        .btnc(btnc), .btnl(btnl), .btnr(btnr),
        .btnu_pulse(btnu_pulse), .btnd_pulse(btnd_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples delayed two edges; a stable level flips once
    // the last D synchronised samples all disagree with it.
    logic [4:0] m_d1 = '0, m_d2 = '0, m_st = '0, m_pulse = '0;
    logic [4:0] diff_q[$];

    task automatic model_edge(input logic r, input logic [4:0] raw);
        logic full;
        if (r) begin
            m_d1 = '0; m_d2 = '0; m_st = '0; m_pulse = '0;
            diff_q.delete();
        end else begin
            diff_q.push_back(m_d2 ^ m_st);
            if (diff_q.size() > D) diff_q.delete(0);
            m_pulse = '0;
            for (int ch = 0; ch < 5; ch++) begin
                full = (diff_q.size() == D);
                for (int i = 0; i < diff_q.size(); i++) full = full & diff_q[i][ch];
                if (full) begin
                    m_st[ch] = ~m_st[ch];
                    if (m_st[ch] && ch >= 3) m_pulse[ch] = 1'b1;
                    for (int i = 0; i < diff_q.size(); i++) diff_q[i][ch] = 1'b0;
                end
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    endtask

    // raw bit order: {d, u, r, l, c}
    task automatic step(input logic r, input logic [4:0] raw);
        rst = r;
        {btnd_in, btnu_in, btnr_in, btnl_in, btnc_in} = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
        edge_n++;
        chk("btnc", int'(btnc), int'(m_st[0]));
        chk("btnl", int'(btnl), int'(m_st[1]));
        chk("btnr", int'(btnr), int'(m_st[2]));
        chk("btnu_pulse", int'(btnu_pulse), int'(m_pulse[3]));
        chk("btnd_pulse", int'(btnd_pulse), int'(m_pulse[4]));
        if (btnu_pulse) begin u_cnt++; if (first_u < 0) first_u = edge_n; end
        if (btnd_pulse) begin d_cnt++; if (first_d < 0) first_d = edge_n; end
        if (btnl) l_seen++;
    endtask

    task automatic clear_counts();
        edge_n = 0; u_cnt = 0; d_cnt = 0; first_u = -1; first_d = -1; l_seen = 0;
    endtask

    initial begin
        logic [4:0] rv;
        logic [5:0] bounce_hi;
        logic [5:0] bounce_lo;
        bounce_hi = 6'b101101;
        bounce_lo = 6'b000010;

        // Reset held with every input high, then released with inputs still high.
        repeat (3) step(1'b1, 5'b11111);
        clear_counts();
        repeat (12) step(1'b0, 5'b11111);
        chk("stuck_u_pulse_count", u_cnt, 1);
        chk("stuck_u_pulse_edge", first_u, D + 2);
        repeat (12) step(1'b0, 5'b00000);

        // Clean press on down, then release.
        clear_counts();
        repeat (20) step(1'b0, 5'b10000);
        chk("press_d_pulse_count", d_cnt, 1);
        chk("press_d_pulse_edge", first_d, D + 2);
        repeat (12) step(1'b0, 5'b00000);
        chk("release_d_no_pulse", d_cnt, 1);

        // Bouncing press then bouncing release on centre.
        for (int i = 5; i >= 0; i--) step(1'b0, {4'b0000, bounce_hi[i]});
        repeat (8) step(1'b0, 5'b00001);
        chk("bounce_c_high", int'(btnc), 1);
        for (int i = 5; i >= 0; i--) step(1'b0, {4'b0000, bounce_lo[i]});
        repeat (8) step(1'b0, 5'b00000);
        chk("bounce_c_low", int'(btnc), 0);

        // Short press on left never qualifies.
        clear_counts();
        repeat (3) step(1'b0, 5'b00010);
        repeat (10) step(1'b0, 5'b00000);
        chk("short_l_never", l_seen, 0);

        // Simultaneous presses.
        clear_counts();
        repeat (10) step(1'b0, 5'b11110);
        chk("simul_u_edge", first_u, D + 2);
        chk("simul_d_edge", first_d, D + 2);
        repeat (12) step(1'b0, 5'b00000);

        // Reset in the middle of a pending press.
        clear_counts();
        repeat (4) step(1'b0, 5'b10000);
        step(1'b1, 5'b10000);
        chk("midrst_no_pulse", d_cnt, 0);
        clear_counts();
        repeat (10) step(1'b0, 5'b10000);
        chk("midrst_pulse_edge", first_d, D + 2);
        chk("midrst_pulse_count", d_cnt, 1);
        repeat (12) step(1'b0, 5'b00000);

        // Random activity: sparse bit flips with occasional reset.
        rv = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
            step($urandom_range(0, 99) == 0, rv);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
